// File: rtl/countdown10k_if.sv
// Bus bundle for the countdown10k interval timer: load strobe/value and count
// enable flow into the timer; state and flags flow out.
interface countdown10k_if #(
    parameter int unsigned WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             reached;
    logic             busy;
    logic [WIDTH-1:0] internal;

    // Controller side: issues loads and enables, observes the timer.
    modport master (
        output load,
        output load_value,
        output enable,
        input  reached,
        input  busy,
        input  internal
    );

    // Timer side.
    modport slave (
        input  load,
        input  load_value,
        input  enable,
        output reached,
        output busy,
        output internal
    );
endinterface

// File: rtl/countdown10k.sv
// countdown10k: loadable down-counter / programmable interval timer.
// Loaded values saturate at MAX; the timer decrements once per enabled tick
// and flags `reached` on hitting zero.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN -- when defined, the count
// reloads from the last loaded value at the end of each interval and `reached`
// becomes a one-cycle pulse instead of a level.
module countdown10k #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MAX   = 10000
) (
    input  logic                tick,
    input  logic                clear,
    countdown10k_if.slave       bus
);
    localparam logic [WIDTH-1:0] MaxW = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] internal_q, internal_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             reached_q, reached_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] load_sat;

    assign load_sat = (bus.load_value > MaxW) ? MaxW : bus.load_value;

    // Next-state: load beats decrement; clear is handled in the flop block.
    always_comb begin
        state_d    = state_q;
        internal_d = internal_q;
        reload_d   = reload_q;
        reached_d  = reached_q;
        busy_d     = busy_q;
        if (bus.load) begin
            internal_d = load_sat;
            reload_d   = load_sat;
            if (load_sat != '0) begin
                state_d   = StRun;
                busy_d    = 1'b1;
                reached_d = 1'b0;
            end else begin
                state_d   = StDone;
                busy_d    = 1'b0;
                reached_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    // The terminal pulse lasts exactly one edge.
                    reached_d = 1'b0;
`endif
                    if (bus.enable) begin
                        if (internal_q > One) begin
                            internal_d = internal_q - One;
                        end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                            internal_d = reload_q;
                            reached_d  = 1'b1;
`else
                            internal_d = '0;
                            state_d    = StDone;
                            busy_d     = 1'b0;
                            reached_d  = 1'b1;
`endif
                        end
                    end
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous active-high clear.
    always_ff @(posedge tick) begin
        if (clear) begin
            state_q    <= StIdle;
            internal_q <= '0;
            reload_q   <= '0;
            reached_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            internal_q <= internal_d;
            reload_q   <= reload_d;
            reached_q  <= reached_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.internal = internal_q;
    assign bus.reached  = reached_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_countdown10k.sv
// Scoreboard bench for countdown10k: each stimulus edge pushes its expected
// outputs; a monitor pops and compares on the following falling edge.
module tb_countdown10k;
`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic [15:0] internal;
        logic        reached;
        logic        busy;
        string       name;
    } exp_t;

    logic tick = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;
    exp_t exp_q[$];

    countdown10k_if #(.WIDTH(16)) bus ();

    countdown10k #(.WIDTH(16), .MAX(10000)) dut (
        .tick  (tick),
        .clear (clear),
        .bus   (bus)
    );

    always #5 tick = ~tick;

    // Monitor: outputs are registered, so every edge presents a result.
    always @(negedge tick) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.internal !== e.internal || bus.reached !== e.reached ||
                bus.busy !== e.busy) begin
                errors++;
                $display("FAIL %s: got internal=%0d reached=%b busy=%b, want internal=%0d reached=%b busy=%b",
                         e.name, bus.internal, bus.reached, bus.busy,
                         e.internal, e.reached, e.busy);
            end
        end
    end

    task automatic step(input logic clr, input logic ld, input logic [15:0] lv,
                        input logic en, input logic [15:0] ei, input logic er,
                        input logic eb, input string nm);
        exp_t e;
        clear          = clr;
        bus.load       = ld;
        bus.load_value = lv;
        bus.enable     = en;
        @(posedge tick);
        e.internal = ei;
        e.reached  = er;
        e.busy     = eb;
        e.name     = nm;
        exp_q.push_back(e);
        @(negedge tick);
        #1;
    endtask

    // Terminal edge differs by mode: reload + pulse vs. zero + level.
    function automatic logic [15:0] term_val(input logic [15:0] n);
        return AUTO ? n : 16'd0;
    endfunction

    initial begin
        clear = 1'b1; bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0;
        @(negedge tick);

        // Reset and count
        step(1, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 1, 0, 0, 0, "idle_enable");
        step(0, 1, 5, 1, 5, 0, 1, "load5");
        for (int k = 4; k >= 1; k--) step(0, 0, 0, 1, 16'(k), 0, 1, "count5");
        step(0, 0, 0, 1, term_val(5), 1, AUTO, "count5_end");
        if (!AUTO) for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 0, 1, 0, "done_hold");
        step(1, 0, 0, 1, 0, 0, 0, "clear1");

        // Saturation and MAX boundary
        step(0, 1, 16'd10001, 0, 10000, 0, 1, "load_max_plus1");
        step(0, 1, 16'd10000, 0, 10000, 0, 1, "load_max");
        step(0, 1, 16'd20000, 1, 10000, 0, 1, "load_20000");
        for (int k = 1; k < 10000; k++) step(0, 0, 0, 1, 16'(10000 - k), 0, 1, "sat_count");
        step(0, 0, 0, 1, term_val(10000), 1, AUTO, "sat_end");
        step(1, 0, 0, 0, 0, 0, 0, "clear2");

        // Pause
        step(0, 1, 3, 0, 3, 0, 1, "load3_pause");
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 3, 0, 1, "pause_hold");
        step(0, 0, 0, 1, 2, 0, 1, "resume2");
        step(0, 0, 0, 1, 1, 0, 1, "resume1");
        step(0, 0, 0, 1, term_val(3), 1, AUTO, "resume_end");
        step(1, 0, 0, 0, 0, 0, 0, "clear3");

        // Zero load
        step(0, 1, 0, 1, 0, 1, 0, "load0");
        step(0, 0, 0, 1, 0, 1, 0, "load0_hold");

        // Clear wins over load/enable mid-count, then restart from DONE
        step(0, 1, 9, 1, 9, 0, 1, "load9");
        step(0, 0, 0, 1, 8, 0, 1, "count8");
        step(0, 0, 0, 1, 7, 0, 1, "count7");
        step(1, 1, 5, 1, 0, 0, 0, "clear_wins");
        step(0, 1, 0, 0, 0, 1, 0, "to_done");
        step(0, 1, 2, 1, 2, 0, 1, "reload_from_done");
        step(0, 0, 0, 1, 1, 0, 1, "restart1");
        step(0, 0, 0, 1, term_val(2), 1, AUTO, "restart_end");

        // Reload during RUN aborts the interval without a pulse
        step(0, 1, 6, 1, 6, 0, 1, "load6");
        step(0, 0, 0, 1, 5, 0, 1, "count5b");
        step(0, 1, 4, 1, 4, 0, 1, "reload_run");
        step(0, 0, 0, 1, 3, 0, 1, "after_reload");
        step(1, 0, 0, 0, 0, 0, 0, "clear4");

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Autoreload: 3,2,1,3,2,1,3,2,1,3 with a pulse on each wrap
        step(0, 1, 3, 1, 3, 0, 1, "auto_load3");
        for (int r = 0; r < 3; r++) begin
            step(0, 0, 0, 1, 2, 0, 1, "auto_2");
            step(0, 0, 0, 1, 1, 0, 1, "auto_1");
            step(0, 0, 0, 1, 3, 1, 1, "auto_wrap");
        end
        step(0, 0, 0, 0, 3, 0, 1, "auto_pulse_drop");
`else
        step(0, 1, 3, 1, 3, 0, 1, "oneshot_load3");
        step(0, 0, 0, 1, 2, 0, 1, "oneshot_2");
        step(0, 0, 0, 1, 1, 0, 1, "oneshot_1");
        for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 0, 1, 0, "oneshot_done");
`endif

        @(negedge tick);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        if (!done) begin
            $display("FAIL timeout: got no completion, want completion within bound");
            $fatal(1, "timeout");
        end
    end
endmodule

// File: doc/countdown10k.md
Name: countdown10k

Overview:
- Loadable down-counter; the counterpart of the 10k up-counter.
- Loaded with a start value of up to MAX, it decrements once per tick while enabled and flags `reached` when it hits zero.
- Used as the programmable interval timer beside the up-counter, on the same tick/clear clock and reset pair.
- State is exported on `internal` for debug and for the bench.

Parameters:
- WIDTH, 16, width of `load_value` and `internal`.
- MAX, 10000, saturation ceiling for loaded values; must be representable in WIDTH bits.

Ports:
- tick  input  1  clock; all state changes on posedge.
- clear  input  1  reset, synchronous, active-high.
- load  input  1  load strobe, sampled on posedge.
- load_value  input  WIDTH  start value captured when `load`=1.
- enable  input  1  count enable; decrement only when high.
- reached  output  1  terminal flag (level, or pulse in autoreload mode).
- busy  output  1  high while counting (state RUN).
- internal  output  WIDTH  current count value.

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered.
- Priority on each posedge: clear > load > enable decrement.
- clear=1:
  - state <= IDLE; internal <= 0; reached <= 0; busy <= 0; reload register <= 0.
  - Takes effect from any state, including mid-count; load and enable are ignored on that edge.
- load=1 (any state, clear=0):
  - v = (load_value > MAX) ? MAX : load_value.
  - internal <= v; reload register <= v; reached <= 0.
  - v != 0: state <= RUN, busy <= 1.
  - v == 0: state <= DONE, reached <= 1, busy <= 0.
  - No decrement occurs on the load edge, even with enable=1.
- RUN, enable=1, internal > 1: internal <= internal - 1.
- RUN, enable=1, internal == 1 (no autoreload): internal <= 0; state <= DONE; busy <= 0; reached <= 1.
- RUN, enable=0: all registers hold.
- DONE: internal = 0, reached = 1, busy = 0. Holds until load or clear; enable has no effect.
- IDLE: internal = 0, reached = 0, busy = 0. Only load leaves IDLE.
- Latency: load N (0 < N ≤ MAX) at edge E with enable held high gives reached = 1 after edge E+N.
  - internal sequence after each edge: N, N-1, …, 1, 0.
- Arithmetic:
  - Unsigned throughout.
  - No underflow: decrement never executes at internal == 0.
  - Comparison against MAX is done at WIDTH bits.
- Reload during RUN: a new load restarts the count from the new v immediately; no reached pulse is produced for the aborted interval.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - In RUN with enable=1 and internal == 1: internal <= reload register; state stays RUN; busy stays 1; reached <= 1 for exactly one cycle.
  - reached returns to 0 on the next edge.
  - Periodic output with period N ticks of enable.
  - v == 0 still goes to DONE with a level reached.
- Not defined: one-shot behaviour as described in Behaviour; the reload register may be optimised away.

Test Plan:
- Reset and count:
  - Stimulus: clear pulse, then load 5 with enable=1 continuously.
  - Required: internal 5,4,3,2,1,0 on successive edges; reached=1 and busy=0 after the 5th post-load edge; both held for 10 further ticks.
- Saturation:
  - Stimulus: load 20000, enable=1.
  - Required: internal=10000 after the load edge; reached rises exactly 10000 edges later, never earlier.
- Pause:
  - Stimulus: load 3, enable=0 for 4 ticks, then enable=1.
  - Required: internal stays 3 and busy=1 during the pause; reached after 3 enabled edges.
- Zero load:
  - Stimulus: load 0.
  - Required: reached=1, busy=0, internal=0 after the load edge.
- Clear and restart:
  - Stimulus: clear asserted when internal=7 in RUN, together with load=1 and enable=1.
  - Required: internal=0, reached=0, busy=0 next edge (clear wins).
  - Then: load 2 from DONE restarts the count; reached drops on the load edge.
- Autoreload (COUNTDOWN_AUTORELOAD_EN defined):
  - Stimulus: load 3, enable=1 for 9 ticks.
  - Required: internal 3,2,1,3,2,1,3,2,1,3; one-cycle reached pulse on each 1→3 transition (3 pulses); busy stays 1.
